simon_io_frontend: RTL and testbench



---
 rtl/simon_io_pkg.sv | 54 +++++
 rtl/simon_debounce.sv | 77 +++++++
 rtl/simon_io_frontend.sv | 164 ++++++++++++++++
 tb/tb_simon_io_frontend.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_io_pkg.sv
// -----------------------------------------------------------------------------
// simon_io_pkg
//
// Shared definitions for the Simon game pad front-end:
//   MS_CNT_W    width of the millisecond-granular hold and scan counters
//   PRESCALE_W  width of the clock-cycle prescaler and ticks_per_milli
//   BLANK_CODE  nibble value that turns a digit dark
//   SEG_FONT    7-segment hex font, bit0 = segment a ... bit6 = segment g,
//               indexed by nibble; entry 15 is the blank pattern
//   seg_pattern final segment drive for one nibble, enable and polarity
// -----------------------------------------------------------------------------
package simon_io_pkg;

   localparam int MS_CNT_W   = 8;
   localparam int PRESCALE_W = 16;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Packed so that SEG_FONT[n] selects the pattern for nibble n.
   // Listed from entry 15 down to entry 0.
   localparam logic [15:0][6:0] SEG_FONT = {
      7'h00,   // F : blank
      7'h79,   // E : a d e f g
      7'h5E,   // d : b c d e g
      7'h39,   // C : a d e f
      7'h7C,   // b : c d e f g
      7'h77,   // A : a b c e f g
      7'h6F,   // 9 : a b c d f g
      7'h7F,   // 8 : all
      7'h07,   // 7 : a b c
      7'h7D,   // 6 : a c d e f g
      7'h6D,   // 5 : a c d f g
      7'h66,   // 4 : b c f g
      7'h4F,   // 3 : a b c d g
      7'h5B,   // 2 : a b d e g
      7'h06,   // 1 : b c
      7'h3F    // 0 : a b c d e f
   };

   // Polarity is applied after blanking, so a blank digit on a common-anode
   // display drives every segment line high (i.e. off).
   function automatic logic [6:0] seg_pattern(input logic [3:0] nib,
                                              input logic       enable,
                                              input logic       invert);
      logic [6:0] raw;
      if ((nib == BLANK_CODE) || !enable) begin
         raw = 7'h00;
      end else begin
         raw = SEG_FONT[nib];
      end
      return raw ^ {7{invert}};
   endfunction

endpackage

// File: rtl/simon_debounce.sv
// -----------------------------------------------------------------------------
// simon_debounce
//
// One button channel: two-flop synchroniser, millisecond hold counter,
// debounced level and a single-cycle press pulse.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset; clears every register
//   tick_i     one-cycle pulse per millisecond
//   btn_raw_i  asynchronous pad level, active-high
//   level_o    debounced level
//   pressed_o  high for one cycle, the cycle after level_o rises
// -----------------------------------------------------------------------------
module simon_debounce
   import simon_io_pkg::*;
#(
   parameter logic [MS_CNT_W-1:0] DEBOUNCE_MS = 8'd10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic btn_raw_i,
   output logic level_o,
   output logic pressed_o
);

   logic                sync1_q;
   logic                sync2_q;
   logic [MS_CNT_W-1:0] hold_q;
   logic [MS_CNT_W-1:0] hold_d;
   logic                level_q;
   logic                level_d;
   logic                level_prev_q;
   logic                pressed_q;

   // The counter only measures how long the synced level has continuously
   // disagreed with the accepted level; any agreement restarts the count,
   // so a glitch shorter than DEBOUNCE_MS ticks never reaches level_q.
   always_comb begin
      hold_d  = hold_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         hold_d = '0;
      end else if (tick_i) begin
         if (hold_q + MS_CNT_W'(1) >= DEBOUNCE_MS) begin
            level_d = sync2_q;
            hold_d  = '0;
         end else begin
            hold_d = hold_q + MS_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         hold_q       <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         pressed_q    <= 1'b0;
      end else begin
         sync1_q      <= btn_raw_i;
         sync2_q      <= sync1_q;
         hold_q       <= hold_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         // Rising edge of the accepted level only; releases are silent.
         pressed_q    <= level_q & ~level_prev_q;
      end
   end

   assign level_o   = level_q;
   assign pressed_o = pressed_q;

endmodule

// File: rtl/simon_io_frontend.sv
// -----------------------------------------------------------------------------
// simon_io_frontend
//
// Pad-side front-end for the Simon game core: millisecond prescaler,
// per-button debounce and a multiplexed hex 7-segment display driver.
//
// Ports:
//   wb_clk_i         system clock
//   wb_rst_i         synchronous active-high reset; all outputs read 0
//   ticks_per_milli  clock cycles per millisecond, may change at any time
//   btn_raw          asynchronous button pads, active-high
//   btn_level        debounced button levels
//   btn_pressed      one-cycle pulse per debounced 0->1 transition
//   milli_tick       one-cycle pulse per millisecond
//   digit_values     nibble i is shown on digit i, 0xF is blank
//   digit_enable     0 blanks the corresponding digit
//   segments_invert  1 inverts segment polarity (common-anode)
//   segments         segments a..g, bit0 = a
//   segment_digits   one-hot active-high digit select
// -----------------------------------------------------------------------------
module simon_io_frontend
   import simon_io_pkg::*;
#(
   parameter int                  N_BTN       = 4,
   parameter int                  N_DIGITS    = 2,
   parameter logic [MS_CNT_W-1:0] DEBOUNCE_MS = 8'd10,
   parameter logic [MS_CNT_W-1:0] SCAN_MS     = 8'd2
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [PRESCALE_W-1:0]   ticks_per_milli,
   input  logic [N_BTN-1:0]        btn_raw,
   output logic [N_BTN-1:0]        btn_level,
   output logic [N_BTN-1:0]        btn_pressed,
   output logic                    milli_tick,
   input  logic [4*N_DIGITS-1:0]   digit_values,
   input  logic [N_DIGITS-1:0]     digit_enable,
   input  logic                    segments_invert,
   output logic [6:0]              segments,
   output logic [N_DIGITS-1:0]     segment_digits
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   // ---------------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------------
   logic [PRESCALE_W-1:0] presc_q;
   logic [PRESCALE_W-1:0] presc_d;
   logic                  tick_q;
   logic                  tick_d;

   // Comparing with >= rather than == lets a runtime decrease of
   // ticks_per_milli below the current count wrap immediately instead of
   // running the counter round through 0xFFFF.
   always_comb begin
      presc_d = presc_q + PRESCALE_W'(1);
      tick_d  = 1'b0;
      if ((ticks_per_milli < PRESCALE_W'(2)) ||
          (presc_q >= ticks_per_milli - PRESCALE_W'(1))) begin
         presc_d = '0;
         tick_d  = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign milli_tick = tick_q;

   // ---------------------------------------------------------------------
   // Buttons
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      simon_debounce #(
         .DEBOUNCE_MS (DEBOUNCE_MS)
      ) u_debounce (
         .clk_i     (wb_clk_i),
         .rst_i     (wb_rst_i),
         .tick_i    (tick_q),
         .btn_raw_i (btn_raw[g]),
         .level_o   (btn_level[g]),
         .pressed_o (btn_pressed[g])
      );
   end

   // ---------------------------------------------------------------------
   // Scan index
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    idx_d;
   logic [MS_CNT_W-1:0] scan_cnt_q;
   logic [MS_CNT_W-1:0] scan_cnt_d;

   always_comb begin
      idx_d      = idx_q;
      scan_cnt_d = scan_cnt_q;
      if (tick_q) begin
         if (scan_cnt_q + MS_CNT_W'(1) >= SCAN_MS) begin
            scan_cnt_d = '0;
            if (idx_q == IDX_W'(N_DIGITS - 1)) begin
               idx_d = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else begin
            scan_cnt_d = scan_cnt_q + MS_CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   // Both the digit select and the segment pattern are derived from idx_d,
   // so they are loaded by the same edge that moves the index and the
   // display never shows one digit's pattern on its neighbour.
   logic [3:0]          nib_sel;
   logic                en_sel;
   logic [6:0]          segments_d;
   logic [N_DIGITS-1:0] digits_d;
   logic [6:0]          segments_q;
   logic [N_DIGITS-1:0] digits_q;

   always_comb begin
      nib_sel  = BLANK_CODE;
      en_sel   = 1'b0;
      digits_d = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            nib_sel     = digit_values[4*i +: 4];
            en_sel      = digit_enable[i];
            digits_d[i] = 1'b1;
         end
      end
      segments_d = seg_pattern(nib_sel, en_sel, segments_invert);
   end

   // Reset forces the pads to 0 regardless of segments_invert.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         idx_q      <= '0;
         scan_cnt_q <= '0;
         segments_q <= '0;
         digits_q   <= '0;
      end else begin
         idx_q      <= idx_d;
         scan_cnt_q <= scan_cnt_d;
         segments_q <= segments_d;
         digits_q   <= digits_d;
      end
   end

   assign segments       = segments_q;
   assign segment_digits = digits_q;

endmodule

// File: tb/tb_simon_io_frontend.sv
module tb_simon_io_frontend;

   localparam int         N_BTN       = 4;
   localparam int         N_DIGITS    = 2;
   localparam int         DV_W        = 4 * N_DIGITS;
   localparam int         DEB         = 10;
   localparam int         SCN         = 2;
   localparam logic [7:0] DEBOUNCE_MS = 8'd10;
   localparam logic [7:0] SCAN_MS     = 8'd2;

   logic                wb_clk_i = 1'b0;
   logic                wb_rst_i = 1'b1;
   logic [15:0]         ticks_per_milli = 16'd100;
   logic [N_BTN-1:0]    btn_raw = '0;
   logic [N_BTN-1:0]    btn_level;
   logic [N_BTN-1:0]    btn_pressed;
   logic                milli_tick;
   logic [DV_W-1:0]     digit_values = '0;
   logic [N_DIGITS-1:0] digit_enable = '1;
   logic                segments_invert = 1'b0;
   logic [6:0]          segments;
   logic [N_DIGITS-1:0] segment_digits;

   always #5 wb_clk_i = ~wb_clk_i;

   simon_io_frontend #(
      .N_BTN       (N_BTN),
      .N_DIGITS    (N_DIGITS),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .SCAN_MS     (SCAN_MS)
   ) dut (
      .wb_clk_i        (wb_clk_i),
      .wb_rst_i        (wb_rst_i),
      .ticks_per_milli (ticks_per_milli),
      .btn_raw         (btn_raw),
      .btn_level       (btn_level),
      .btn_pressed     (btn_pressed),
      .milli_tick      (milli_tick),
      .digit_values    (digit_values),
      .digit_enable    (digit_enable),
      .segments_invert (segments_invert),
      .segments        (segments),
      .segment_digits  (segment_digits)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural reference: expected value of every output after each edge.
   int                  m_elapsed;        // cycles spent in the current ms
   logic                m_tick;
   logic [N_BTN-1:0]    m_level;
   logic [N_BTN-1:0]    m_pressed;
   logic [N_BTN-1:0]    m_rose;           // level rose at the previous edge
   logic [N_BTN-1:0]    m_seen1, m_seen2; // pad value 1 and 2 edges ago
   int                  m_disagree [N_BTN];
   int                  m_idx;
   int                  m_scan_ms;
   logic [6:0]          m_seg;
   logic [N_DIGITS-1:0] m_dig;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
         4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
         4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
         4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;
         default: return 7'h00;
      endcase
   endfunction

   // Advance one clock: capture what the DUT samples, clock, update the
   // reference from the rules, then sample point 1 unit after the edge.
   task automatic step();
      logic                rst_s, inv_s, old_tick;
      logic [15:0]         tpm_s;
      logic [N_BTN-1:0]    raw_s, new_level;
      logic [DV_W-1:0]     dv_s;
      logic [N_DIGITS-1:0] en_s;
      logic [3:0]          nib;
      rst_s = wb_rst_i; inv_s = segments_invert; tpm_s = ticks_per_milli;
      raw_s = btn_raw;  dv_s = digit_values;      en_s = digit_enable;
      @(posedge wb_clk_i);
      if (rst_s) begin
         m_elapsed = 0; m_tick = 1'b0; m_level = '0; m_pressed = '0; m_rose = '0;
         m_seen1 = '0; m_seen2 = '0; m_idx = 0; m_scan_ms = 0;
         m_seg = '0; m_dig = '0;
         for (int i = 0; i < N_BTN; i++) m_disagree[i] = 0;
      end else begin
         old_tick = m_tick;
         if (tpm_s < 16'd2 || m_elapsed + 1 >= int'(tpm_s)) begin
            m_tick = 1'b1; m_elapsed = 0;
         end else begin
            m_tick = 1'b0; m_elapsed = m_elapsed + 1;
         end
         m_pressed = m_rose;
         new_level = m_level;
         for (int i = 0; i < N_BTN; i++) begin
            if (m_seen2[i] == m_level[i]) m_disagree[i] = 0;
            else if (old_tick) begin
               m_disagree[i] = m_disagree[i] + 1;
               if (m_disagree[i] == DEB) begin
                  new_level[i] = m_seen2[i]; m_disagree[i] = 0;
               end
            end
         end
         m_rose  = new_level & ~m_level;
         m_level = new_level;
         m_seen2 = m_seen1; m_seen1 = raw_s;
         if (old_tick) begin
            m_scan_ms = m_scan_ms + 1;
            if (m_scan_ms == SCN) begin
               m_scan_ms = 0; m_idx = (m_idx + 1) % N_DIGITS;
            end
         end
         m_dig = N_DIGITS'(1) << m_idx;
         nib   = dv_s[4*m_idx +: 4];
         m_seg = ((nib == 4'hF || !en_s[m_idx]) ? 7'h00 : font(nib)) ^ {7{inv_s}};
      end
      #1;
   endtask

   task automatic test_reset();
      int lat;
      wb_rst_i = 1'b1; segments_invert = 1'b1; ticks_per_milli = 16'd100;
      btn_raw = N_BTN'($urandom); digit_values = DV_W'($urandom);
      for (int n = 0; n < 3; n++) begin
         step();
         checks++;
         if ({btn_level, btn_pressed, milli_tick, segments, segment_digits} !== '0)
            begin failures++; $display("FAIL reset_outputs got=%h want=0",
               {btn_level, btn_pressed, milli_tick, segments, segment_digits}); end
      end
      btn_raw = '0; segments_invert = 1'b0; digit_values = 8'h7A; digit_enable = '1;
      wb_rst_i = 1'b0;
      step();
      checks++;
      if (segment_digits !== 2'b01) begin failures++;
         $display("FAIL reset_first_digit got=%b want=01", segment_digits); end
      checks++;
      if (segments !== 7'h77) begin failures++;
         $display("FAIL reset_first_segments got=%h want=77", segments); end
      checks++;
      if (milli_tick !== 1'b0) begin failures++;
         $display("FAIL reset_tick_early got=%b want=0", milli_tick); end
      lat = 0;
      for (int n = 2; n <= 200; n++) begin
         step();
         if (milli_tick === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (lat != 100) begin failures++;
         $display("FAIL reset_first_tick cycles=%0d want=100", lat); end
   endtask

   task automatic test_prescaler();
      int gap;
      ticks_per_milli = 16'd100;
      gap = 0;
      for (int n = 1; n <= 250; n++) begin
         step();
         if (milli_tick === 1'b1) begin gap = n; break; end
      end
      checks++;
      if (gap != 100) begin failures++;
         $display("FAIL presc_period_100 got=%0d want=100", gap); end
      step();
      checks++;
      if (milli_tick !== 1'b0) begin failures++;
         $display("FAIL presc_tick_width got=%b want=0", milli_tick); end
      for (int n = 0; n < 49; n++) step();
      ticks_per_milli = 16'd10;
      step();
      checks++;
      if (milli_tick !== 1'b1) begin failures++;
         $display("FAIL presc_lowered_tick got=%b want=1", milli_tick); end
      for (int k = 0; k < 2; k++) begin
         gap = 0;
         for (int n = 1; n <= 50; n++) begin
            step();
            if (milli_tick === 1'b1) begin gap = n; break; end
         end
         checks++;
         if (gap != 10) begin failures++;
            $display("FAIL presc_period_10 got=%0d want=10", gap); end
      end
      for (int t = 0; t < 2; t++) begin
         ticks_per_milli = 16'(t);
         step();
         for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if (milli_tick !== 1'b1) begin failures++;
               $display("FAIL presc_every_cycle tpm=%0d got=%b want=1", t, milli_tick); end
         end
      end
      for (int k = 0; k < 3; k++) begin
         ticks_per_milli = 16'($urandom_range(2, 30));
         for (int n = 0; n < 150; n++) begin
            step();
            checks++;
            if (milli_tick !== m_tick) begin failures++;
               $display("FAIL presc_random tpm=%0d got=%b want=%b", ticks_per_milli, milli_tick, m_tick); end
         end
      end
   endtask

   task automatic test_debounce();
      int lat, pulses;
      ticks_per_milli = 16'd10; btn_raw = '0;
      for (int n = 0; n < 30; n++) step();
      for (int n = 0; n < 200; n++) begin
         btn_raw[2] = (n < 50);
         step();
         checks++;
         if (btn_level !== '0 || btn_pressed !== '0) begin failures++;
            $display("FAIL deb_glitch level=%b pressed=%b want=0", btn_level, btn_pressed); end
      end
      btn_raw[2] = 1'b1;
      lat = 0;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (btn_level[2] === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (lat < 93 || lat > 102) begin failures++;
         $display("FAIL deb_latency cycles=%0d want=93..102", lat); end
      checks++;
      if (btn_pressed !== 4'b0000) begin failures++;
         $display("FAIL deb_pulse_early got=%b want=0000", btn_pressed); end
      step();
      checks++;
      if (btn_pressed !== 4'b0100) begin failures++;
         $display("FAIL deb_pulse got=%b want=0100", btn_pressed); end
      step();
      checks++;
      if (btn_pressed !== 4'b0000) begin failures++;
         $display("FAIL deb_pulse_width got=%b want=0000", btn_pressed); end
      btn_raw[2] = 1'b0;
      pulses = 0;
      for (int n = 0; n < 150; n++) begin
         step();
         if (btn_pressed !== '0) pulses++;
      end
      checks++;
      if (pulses != 0 || btn_level !== '0) begin failures++;
         $display("FAIL deb_release pulses=%0d level=%b want 0/0000", pulses, btn_level); end
   endtask

   task automatic test_simultaneous();
      logic [N_BTN-1:0] seen;
      btn_raw = 4'b1001;
      seen = '0;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (btn_pressed !== '0) begin seen = btn_pressed; break; end
      end
      checks++;
      if (seen !== 4'b1001) begin failures++;
         $display("FAIL simul_pulses got=%b want=1001", seen); end
      btn_raw = '0;
      for (int n = 0; n < 150; n++) step();
      for (int n = 0; n < 300; n++) begin
         btn_raw[1] = ((n / 10) % 2 == 0);
         step();
         checks++;
         if (btn_level !== '0 || btn_pressed !== '0) begin failures++;
            $display("FAIL chatter level=%b pressed=%b want=0", btn_level, btn_pressed); end
      end
      btn_raw = '0;
      for (int n = 0; n < 20; n++) step();
   endtask

   task automatic test_scan();
      logic [N_DIGITS-1:0] prev;
      logic [6:0]          want;
      int                  trans, dig1;
      ticks_per_milli = 16'd5; digit_values = 8'h7A; digit_enable = 2'b11;
      segments_invert = 1'b0;
      for (int n = 0; n < 30; n++) step();
      prev = segment_digits; trans = 0;
      for (int n = 0; n < 100; n++) begin
         step();
         if (segment_digits !== prev) trans++;
         prev = segment_digits;
         want = (segment_digits === 2'b01) ? 7'h77 : 7'h07;
         checks++;
         if ((segment_digits !== 2'b01 && segment_digits !== 2'b10) || segments !== want)
            begin failures++; $display("FAIL scan_7A sel=%b seg=%h want_seg=%h", segment_digits, segments, want); end
      end
      checks++;
      if (trans != 10) begin failures++;
         $display("FAIL scan_rate transitions=%0d want=10", trans); end
      for (int k = 0; k < 3; k++) begin
         segments_invert = (k == 0);
         digit_values    = (k == 1) ? 8'hF7 : 8'h7A;
         digit_enable    = (k == 2) ? 2'b01 : 2'b11;
         step();
         dig1 = 0;
         for (int n = 0; n < 40; n++) begin
            step();
            if (segment_digits === 2'b10) dig1++;
            if (k == 0) want = (segment_digits === 2'b01) ? 7'h08 : 7'h78;
            else if (k == 1) want = (segment_digits === 2'b01) ? 7'h07 : 7'h00;
            else want = (segment_digits === 2'b01) ? 7'h77 : 7'h00;
            checks++;
            if (segments !== want || segments !== m_seg || segment_digits !== m_dig) begin failures++;
               $display("FAIL scan_mode%0d sel=%b seg=%h want_seg=%h", k, segment_digits, segments, want); end
         end
         checks++;
         if (dig1 != 20) begin failures++;
            $display("FAIL scan_select_mode%0d digit1_cycles=%0d want=20", k, dig1); end
      end
      segments_invert = 1'b0; digit_values = 8'h7A; digit_enable = 2'b11;
   endtask

   task automatic test_reset_mid();
      int lat;
      ticks_per_milli = 16'd10; btn_raw = 4'b0001; segments_invert = 1'b1;
      for (int n = 0; n < 200 && btn_level[0] !== 1'b1; n++) step();
      for (int n = 0; n < 60 && segment_digits !== 2'b10; n++) step();
      checks++;
      if (btn_level[0] !== 1'b1 || segment_digits !== 2'b10) begin failures++;
         $display("FAIL midrst_setup level=%b sel=%b want 1/10", btn_level[0], segment_digits); end
      wb_rst_i = 1'b1;
      for (int n = 0; n < 2; n++) begin
         step();
         checks++;
         if ({btn_level, btn_pressed, milli_tick, segments, segment_digits} !== '0)
            begin failures++; $display("FAIL midrst_outputs got=%h want=0",
               {btn_level, btn_pressed, milli_tick, segments, segment_digits}); end
      end
      wb_rst_i = 1'b0;
      step();
      checks++;
      if (segment_digits !== 2'b01 || segments !== 7'h08) begin failures++;
         $display("FAIL midrst_restart sel=%b seg=%h want 01/08", segment_digits, segments); end
      lat = 0;
      for (int n = 2; n <= 200; n++) begin
         step();
         if (btn_pressed[0] === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (lat != 102) begin failures++;
         $display("FAIL midrst_press cycles=%0d want=102", lat); end
      btn_raw = '0; segments_invert = 1'b0;
   endtask

   task automatic test_random();
      int hold [N_BTN];
      for (int i = 0; i < N_BTN; i++) hold[i] = int'($urandom_range(1, 60));
      ticks_per_milli = 16'($urandom_range(3, 8));
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 499) ticks_per_milli = 16'($urandom_range(0, 8));
         if (n % 7 == 0)     digit_values    = DV_W'($urandom);
         if (n % 97 == 0)    digit_enable    = N_DIGITS'($urandom);
         if (n % 131 == 0)   segments_invert = 1'($urandom);
         for (int i = 0; i < N_BTN; i++) begin
            hold[i] = hold[i] - 1;
            if (hold[i] <= 0) begin
               btn_raw[i] = ~btn_raw[i];
               hold[i] = int'($urandom_range(1, 120));
            end
         end
         step();
         checks++;
         if ({btn_level, btn_pressed, milli_tick, segments, segment_digits} !==
             {m_level, m_pressed, m_tick, m_seg, m_dig}) begin failures++;
            $display("FAIL random_model cyc=%0d got=%h want=%h", n,
               {btn_level, btn_pressed, milli_tick, segments, segment_digits},
               {m_level, m_pressed, m_tick, m_seg, m_dig});
         end
      end
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_debounce();
      test_simultaneous();
      test_scan();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
